// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 read controller: FSM states, error codes,
// frame byte positions and the millisecond-to-cycle conversion.
package dht11_pkg;

  typedef enum logic [2:0] {
    ESPERA_INTERVALO = 3'd0,
    OCIOSO           = 3'd1,
    HABILITA         = 3'd2,
    AGUARDA_DONE     = 3'd3,
    VERIFICA         = 3'd4,
    FALHA            = 3'd5,
    LIBERA           = 3'd6
  } estado_t;

  localparam logic [1:0] ERRO_OK       = 2'd0;
  localparam logic [1:0] ERRO_SENSOR   = 2'd1;
  localparam logic [1:0] ERRO_CHECKSUM = 2'd2;
  localparam logic [1:0] ERRO_WATCHDOG = 2'd3;

  // LSB position of each byte inside the 40-bit frame
  localparam int POS_UMID_INT = 32;
  localparam int POS_UMID_DEC = 24;
  localparam int POS_TEMP_INT = 16;
  localparam int POS_TEMP_DEC = 8;
  localparam int POS_CHECKSUM = 0;

  function automatic int unsigned ms_para_ciclos(input int unsigned freq_hz,
                                                 input int unsigned ms);
    return (freq_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit; resets to 0.
module sincronizador_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sinc_q;

  // Shift the asynchronous input through two flops
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: flops are written with <= so every register samples pre-edge values.
    if (!reset_n) begin
      meta_q <= 1'b0;
      sinc_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/controlador_leitura_dht11.sv
// DHT11 read sequencer: accepts host requests, pulses the receiver enable,
// checks the frame checksum, retries failed attempts and enforces the sensor's
// minimum interval between reads. Optional diagnostic failure counters are
// compiled in when DHT11_DIAG_EN is defined.
module controlador_leitura_dht11
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ         = 50_000_000,
  parameter int unsigned INTERVALO_MIN_MS    = 2000,
  parameter int unsigned TIMEOUT_MS          = 100,
  parameter int unsigned MAX_TENTATIVAS      = 3,
  parameter int unsigned CICLOS_ENABLE_BAIXO = 200
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        requisicao,
  output logic        ocupado,
  output logic        enable_sensor,
  input  logic [39:0] dados_sensor,
  input  logic        erro_sensor,
  input  logic        done_sensor,
  output logic [7:0]  umidade_int,
  output logic [7:0]  umidade_dec,
  output logic [7:0]  temperatura_int,
  output logic [7:0]  temperatura_dec,
  output logic        valido,
  output logic [1:0]  codigo_erro
`ifdef DHT11_DIAG_EN
  ,
  output logic [15:0] cont_falha_checksum,
  output logic [15:0] cont_falha_sensor
`endif
);

  localparam int unsigned N_INTERVALO = ms_para_ciclos(CLK_FREQ_HZ, INTERVALO_MIN_MS);
  localparam int unsigned N_TIMEOUT   = ms_para_ciclos(CLK_FREQ_HZ, TIMEOUT_MS);
  localparam int unsigned N_LIBERA    = CICLOS_ENABLE_BAIXO;

  logic done_s, erro_s;

  sincronizador_2ff u_sinc_done (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (done_sensor),
    .q_o     (done_s)
  );

  sincronizador_2ff u_sinc_erro (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (erro_sensor),
    .q_o     (erro_s)
  );

  estado_t     estado_q, estado_d;
  logic [31:0] cont_q, cont_d;
  logic [7:0]  tentativas_q, tentativas_d;
  logic [39:0] quadro_q, quadro_d;
  logic [1:0]  codigo_tent_q, codigo_tent_d;
  logic [1:0]  codigo_erro_q, codigo_erro_d;
  logic        conclusao_q, conclusao_d;
  logic        ocupado_q, ocupado_d;
  logic [7:0]  umid_int_q, umid_int_d, umid_dec_q, umid_dec_d;
  logic [7:0]  temp_int_q, temp_int_d, temp_dec_q, temp_dec_d;

  logic       fim_intervalo, fim_watchdog, fim_libera, checksum_ok;
  logic [7:0] soma;

  // One shared counter times the interval, the watchdog and the enable-low hold
  assign fim_intervalo = (cont_q == 32'(N_INTERVALO - 1));
  assign fim_watchdog  = (cont_q == 32'(N_TIMEOUT - 1));
  assign fim_libera    = (cont_q == 32'(N_LIBERA - 1));

  assign soma = quadro_q[POS_UMID_INT +: 8] + quadro_q[POS_UMID_DEC +: 8]
              + quadro_q[POS_TEMP_INT +: 8] + quadro_q[POS_TEMP_DEC +: 8];
  assign checksum_ok = (soma == quadro_q[POS_CHECKSUM +: 8]);

  // State register; reset lands in the interval wait so the sensor can settle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado_q <= ESPERA_INTERVALO;
    else          estado_q <= estado_d;
  end

  // Next-state decision
  always_comb begin
    // NOTE: default assignment first so no path leaves estado_d unassigned (no latch).
    estado_d = estado_q;
    case (estado_q)
      ESPERA_INTERVALO: if (fim_intervalo)
                          estado_d = (tentativas_q == 8'd0) ? OCIOSO : HABILITA;
      OCIOSO:           if (requisicao) estado_d = HABILITA;
      HABILITA:         estado_d = AGUARDA_DONE;
      AGUARDA_DONE:     if (done_s)            estado_d = erro_s ? FALHA : VERIFICA;
                        else if (fim_watchdog) estado_d = FALHA;
      VERIFICA:         estado_d = checksum_ok ? LIBERA : FALHA;
      FALHA:            estado_d = LIBERA;
      LIBERA:           if (fim_libera) estado_d = ESPERA_INTERVALO;
      default:          estado_d = ESPERA_INTERVALO;
    endcase
  end

  // Outputs decoded from state; enable falls with reset since estado_q resets
  always_comb begin
    enable_sensor = 1'b0;
    valido        = 1'b0;
    case (estado_q)
      HABILITA, AGUARDA_DONE, VERIFICA, FALHA: enable_sensor = 1'b1;
      LIBERA:  valido = conclusao_q && fim_libera;
      default: ;
    endcase
  end

  // Datapath next values: counters, attempts, captured frame, results
  always_comb begin
    cont_d        = (estado_d != estado_q) ? 32'd0 : cont_q + 32'd1;
    tentativas_d  = tentativas_q;
    quadro_d      = quadro_q;
    codigo_tent_d = codigo_tent_q;
    codigo_erro_d = codigo_erro_q;
    conclusao_d   = conclusao_q;
    ocupado_d     = ocupado_q;
    umid_int_d    = umid_int_q;
    umid_dec_d    = umid_dec_q;
    temp_int_d    = temp_int_q;
    temp_dec_d    = temp_dec_q;
    case (estado_q)
      OCIOSO: if (requisicao) begin
        ocupado_d    = 1'b1;
        tentativas_d = 8'd1;
      end
      AGUARDA_DONE: begin
        // The receiver holds its frame until enable falls, so a raw capture is safe
        if (done_s) begin
          quadro_d = dados_sensor;
          if (erro_s) codigo_tent_d = ERRO_SENSOR;
        end else if (fim_watchdog) begin
          codigo_tent_d = ERRO_WATCHDOG;
        end
      end
      VERIFICA: if (checksum_ok) begin
        umid_int_d    = quadro_q[POS_UMID_INT +: 8];
        umid_dec_d    = quadro_q[POS_UMID_DEC +: 8];
        temp_int_d    = quadro_q[POS_TEMP_INT +: 8];
        temp_dec_d    = quadro_q[POS_TEMP_DEC +: 8];
        codigo_erro_d = ERRO_OK;
        conclusao_d   = 1'b1;
      end else begin
        codigo_tent_d = ERRO_CHECKSUM;
      end
      FALHA: if (tentativas_q < 8'(MAX_TENTATIVAS)) begin
        tentativas_d = tentativas_q + 8'd1;
        conclusao_d  = 1'b0;
      end else begin
        conclusao_d   = 1'b1;
        codigo_erro_d = codigo_tent_q;
      end
      LIBERA: if (fim_libera && conclusao_q) begin
        ocupado_d    = 1'b0;
        tentativas_d = 8'd0;
        conclusao_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; everything clears on reset, including the good values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont_q        <= '0;
      tentativas_q  <= '0;
      quadro_q      <= '0;
      codigo_tent_q <= ERRO_OK;
      codigo_erro_q <= ERRO_OK;
      conclusao_q   <= 1'b0;
      ocupado_q     <= 1'b0;
      umid_int_q    <= '0;
      umid_dec_q    <= '0;
      temp_int_q    <= '0;
      temp_dec_q    <= '0;
    end else begin
      cont_q        <= cont_d;
      tentativas_q  <= tentativas_d;
      quadro_q      <= quadro_d;
      codigo_tent_q <= codigo_tent_d;
      codigo_erro_q <= codigo_erro_d;
      conclusao_q   <= conclusao_d;
      ocupado_q     <= ocupado_d;
      umid_int_q    <= umid_int_d;
      umid_dec_q    <= umid_dec_d;
      temp_int_q    <= temp_int_d;
      temp_dec_q    <= temp_dec_d;
    end
  end

  assign ocupado         = ocupado_q;
  assign codigo_erro     = codigo_erro_q;
  assign umidade_int     = umid_int_q;
  assign umidade_dec     = umid_dec_q;
  assign temperatura_int = temp_int_q;
  assign temperatura_dec = temp_dec_q;

`ifdef DHT11_DIAG_EN
  logic [15:0] cont_cs_q, cont_sens_q;

  // Saturating per-cause failure counters, one step per failed attempt
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont_cs_q   <= '0;
      cont_sens_q <= '0;
    end else if (estado_q == FALHA) begin
      if (codigo_tent_q == ERRO_CHECKSUM) begin
        if (cont_cs_q != 16'hFFFF) cont_cs_q <= cont_cs_q + 16'd1;
      end else begin
        if (cont_sens_q != 16'hFFFF) cont_sens_q <= cont_sens_q + 16'd1;
      end
    end
  end

  assign cont_falha_checksum = cont_cs_q;
  assign cont_falha_sensor   = cont_sens_q;
`endif

endmodule
